// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file types for the writeback path
package cpu_pkg;

   localparam int NUM_REGS = 16;

   typedef logic [3:0]  reg_idx_t;
   typedef logic [31:0] word_t;

   typedef struct packed {
      reg_idx_t index;
      word_t    data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback requests
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module wb_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  logic    i_push,
   input  wb_req_t i_push_data,
   input  logic    i_pop,
   output wb_req_t o_pop_data,
   output logic    o_full,
   output logic    o_empty
);

   wb_req_t         r_mem [DEPTH];
   logic   [AW:0]   r_wr_ptr;
   logic   [AW:0]   r_rd_ptr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         if (i_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
   end

   assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty    = (r_wr_ptr == r_rd_ptr);
   assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && o_full));
   a_no_pop_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_pop && o_empty));

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - ALU/load writeback arbiter with RAW scoreboard
// Optional WRITEBACK_BYPASS_EN adds same-cycle bypass outputs.
module writeback_unit
   import cpu_pkg::*;
#(
   parameter int LQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_async_n,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [3:0]  alu_index,
   input  logic [31:0] alu_data,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [3:0]  mem_index,
   input  logic [31:0] mem_data,
   input  logic        issue_en,
   input  logic [3:0]  issue_index,
   input  logic [3:0]  query_a_index,
   input  logic [3:0]  query_b_index,
   input  logic [3:0]  query_c_index,
   output logic        pending_a,
   output logic        pending_b,
   output logic        pending_c,
`ifdef WRITEBACK_BYPASS_EN
   output logic        bypass_a,
   output logic        bypass_b,
   output logic        bypass_c,
   output logic [31:0] bypass_data,
`endif
   output logic        write_en,
   output logic [3:0]  write_index,
   output logic [31:0] write
);

   localparam int LQ_AW = $clog2(LQ_DEPTH);

   wb_req_t               w_head;
   wb_req_t               w_sel;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_alu_acc;
   logic                  w_sel_valid;

   logic                  r_write_en;
   reg_idx_t              r_write_index;
   word_t                 r_write;
   logic [NUM_REGS-1:0]   r_pending;

   wb_fifo #(.DEPTH(LQ_DEPTH), .AW(LQ_AW)) u_load_q (
      .i_clk       (clk),
      .i_rst_n     (rst_async_n),
      .i_push      (w_push),
      .i_push_data ({mem_index, mem_data}),
      .i_pop       (w_pop),
      .o_pop_data  (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   // A full queue always drains first so loads cannot be starved by the ALU.
   assign alu_ready   = !w_full;
   assign mem_ready   = !w_full;
   assign w_push      = mem_valid && !w_full;
   assign w_alu_acc   = alu_valid && !w_full;
   assign w_pop       = w_full || (!alu_valid && !w_empty);
   assign w_sel_valid = w_alu_acc || w_pop;
   assign w_sel       = w_alu_acc ? wb_req_t'({alu_index, alu_data}) : w_head;

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         r_write_en    <= 1'b0;
         r_write_index <= '0;
         r_write       <= '0;
      end else begin
         r_write_en <= w_sel_valid && (w_sel.index != '0);
         if (w_sel_valid && (w_sel.index != '0)) begin
            r_write_index <= w_sel.index;
            r_write       <= w_sel.data;
         end
      end
   end

   // Set beats clear when decode re-issues the register being written back.
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         r_pending <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (issue_en && (issue_index == reg_idx_t'(i)))
               r_pending[i] <= 1'b1;
            else if (r_write_en && (r_write_index == reg_idx_t'(i)))
               r_pending[i] <= 1'b0;
         end
         r_pending[0] <= 1'b0;
      end
   end

   assign write_en    = r_write_en;
   assign write_index = r_write_index;
   assign write       = r_write;

`ifdef WRITEBACK_BYPASS_EN
   assign bypass_a    = r_write_en && (r_write_index == query_a_index) && (query_a_index != '0);
   assign bypass_b    = r_write_en && (r_write_index == query_b_index) && (query_b_index != '0);
   assign bypass_c    = r_write_en && (r_write_index == query_c_index) && (query_c_index != '0);
   assign bypass_data = r_write;
   assign pending_a   = r_pending[query_a_index] && !bypass_a;
   assign pending_b   = r_pending[query_b_index] && !bypass_b;
   assign pending_c   = r_pending[query_c_index] && !bypass_c;
`else
   assign pending_a   = r_pending[query_a_index];
   assign pending_b   = r_pending[query_b_index];
   assign pending_c   = r_pending[query_c_index];
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_async_n;
   logic        alu_valid, mem_valid, issue_en;
   logic        alu_ready, mem_ready;
   logic [3:0]  alu_index, mem_index, issue_index;
   logic [31:0] alu_data, mem_data;
   logic [3:0]  query_a_index, query_b_index, query_c_index;
   logic        pending_a, pending_b, pending_c;
   logic        write_en;
   logic [3:0]  write_index;
   logic [31:0] write;
`ifdef WRITEBACK_BYPASS_EN
   logic        bypass_a, bypass_b, bypass_c;
   logic [31:0] bypass_data;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   writeback_unit #(.LQ_DEPTH(4)) dut (
      .clk           (clk),
      .rst_async_n   (rst_async_n),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_index     (alu_index),
      .alu_data      (alu_data),
      .mem_valid     (mem_valid),
      .mem_ready     (mem_ready),
      .mem_index     (mem_index),
      .mem_data      (mem_data),
      .issue_en      (issue_en),
      .issue_index   (issue_index),
      .query_a_index (query_a_index),
      .query_b_index (query_b_index),
      .query_c_index (query_c_index),
      .pending_a     (pending_a),
      .pending_b     (pending_b),
      .pending_c     (pending_c),
`ifdef WRITEBACK_BYPASS_EN
      .bypass_a      (bypass_a),
      .bypass_b      (bypass_b),
      .bypass_c      (bypass_c),
      .bypass_data   (bypass_data),
`endif
      .write_en      (write_en),
      .write_index   (write_index),
      .write         (write)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_async_n = 1'b0;
      alu_valid = 0; mem_valid = 0; issue_en = 0;
      alu_index = 0; mem_index = 0; issue_index = 0;
      alu_data = 0; mem_data = 0;
      query_a_index = 0; query_b_index = 0; query_c_index = 0;
      tick(); tick();
      checks++;
      if ({write_en, write_index, write} !== 37'd0) begin
         failures++;
         $display("FAIL reset_out got=%b/%h/%h want 0/0/0", write_en, write_index, write);
      end
      checks++;
      if ({pending_a, pending_b, pending_c} !== 3'b000) begin
         failures++;
         $display("FAIL reset_pending got=%b want 000", {pending_a, pending_b, pending_c});
      end
      rst_async_n = 1'b1;
      checks++;
      if ({alu_ready, mem_ready} !== 2'b11) begin
         failures++;
         $display("FAIL reset_ready got=%b want 11", {alu_ready, mem_ready});
      end
   endtask

   task automatic test_alu_only();
      query_a_index = 4'd3;
      issue_en = 1; issue_index = 4'd3;
      tick();
      issue_en = 0;
      checks++;
      if (pending_a !== 1'b1) begin
         failures++;
         $display("FAIL alu_pending_set got=%b want 1", pending_a);
      end
      alu_valid = 1; alu_index = 4'd3; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 0;
      checks++;
      if ({write_en, write_index, write} !== {1'b1, 4'd3, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL alu_write got=%b/%h/%h want 1/3/deadbeef", write_en, write_index, write);
      end
`ifdef WRITEBACK_BYPASS_EN
      checks++;
      if ({pending_a, bypass_a} !== 2'b01) begin
         failures++;
         $display("FAIL alu_bypass got=%b want 01", {pending_a, bypass_a});
      end
`else
      checks++;
      if (pending_a !== 1'b1) begin
         failures++;
         $display("FAIL alu_pending_wcycle got=%b want 1", pending_a);
      end
`endif
      tick();
      checks++;
      if ({write_en, pending_a, write} !== {2'b00, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL alu_after got=%b/%b/%h want 0/0/deadbeef", write_en, pending_a, write);
      end
   endtask

   task automatic test_contention();
      mem_valid = 1; mem_index = 4'd5; mem_data = 32'h11;
      tick();
      alu_valid = 1; alu_index = 4'd6; alu_data = 32'h22;
      mem_index = 4'd7; mem_data = 32'h33;
      tick();
      alu_valid = 0; mem_valid = 0;
      checks++;
      if ({write_en, write_index, write} !== {1'b1, 4'd6, 32'h22}) begin
         failures++;
         $display("FAIL cont_first got=%b/%h/%h want 1/6/22", write_en, write_index, write);
      end
      tick();
      checks++;
      if ({write_en, write_index, write} !== {1'b1, 4'd5, 32'h11}) begin
         failures++;
         $display("FAIL cont_second got=%b/%h/%h want 1/5/11", write_en, write_index, write);
      end
      tick();
      checks++;
      if ({write_en, write_index, write} !== {1'b1, 4'd7, 32'h33}) begin
         failures++;
         $display("FAIL cont_third got=%b/%h/%h want 1/7/33", write_en, write_index, write);
      end
      tick();
      checks++;
      if (write_en !== 1'b0) begin
         failures++;
         $display("FAIL cont_idle got=%b want 0", write_en);
      end
   endtask

   task automatic test_queue_full();
      alu_valid = 1; alu_index = 4'd8; alu_data = 32'h88;
      mem_valid = 1;
      for (int i = 0; i < 4; i++) begin
         mem_index = 4'(9 + i);
         mem_data  = 32'h1000 + 32'(9 + i);
         tick();
      end
      mem_index = 4'd13; mem_data = 32'h100D;
      checks++;
      if ({mem_ready, alu_ready} !== 2'b00) begin
         failures++;
         $display("FAIL full_ready got=%b want 00", {mem_ready, alu_ready});
      end
      checks++;
      if ({write_en, write_index} !== {1'b1, 4'd8}) begin
         failures++;
         $display("FAIL full_alu_write got=%b/%h want 1/8", write_en, write_index);
      end
      tick();
      checks++;
      if ({write_en, write_index, write} !== {1'b1, 4'd9, 32'h1009}) begin
         failures++;
         $display("FAIL full_head got=%b/%h/%h want 1/9/1009", write_en, write_index, write);
      end
      checks++;
      if ({alu_ready, mem_ready} !== 2'b11) begin
         failures++;
         $display("FAIL full_ready_back got=%b want 11", {alu_ready, mem_ready});
      end
      alu_valid = 0; mem_valid = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({write_en, write_index, write} !== {1'b1, 4'(10 + i), 32'h1000 + 32'(10 + i)}) begin
            failures++;
            $display("FAIL full_drain%0d got=%b/%h/%h want 1/%h/%h", i, write_en, write_index,
                     write, 4'(10 + i), 32'h1000 + 32'(10 + i));
         end
      end
      tick();
      checks++;
      if (write_en !== 1'b0) begin
         failures++;
         $display("FAIL full_idle got=%b want 0", write_en);
      end
   endtask

   task automatic test_r0();
      query_a_index = 4'd0;
      alu_valid = 1; alu_index = 4'd0; alu_data = 32'hFFFFFFFF;
      issue_en = 1; issue_index = 4'd0;
      checks++;
      if (alu_ready !== 1'b1) begin
         failures++;
         $display("FAIL r0_ready got=%b want 1", alu_ready);
      end
      tick();
      alu_valid = 0; issue_en = 0;
      checks++;
      if ({write_en, write_index, write} !== {1'b0, 4'd12, 32'h100C}) begin
         failures++;
         $display("FAIL r0_write got=%b/%h/%h want 0/c/100c", write_en, write_index, write);
      end
      checks++;
      if (pending_a !== 1'b0) begin
         failures++;
         $display("FAIL r0_pending got=%b want 0", pending_a);
      end
      tick();
      checks++;
      if (write_en !== 1'b0) begin
         failures++;
         $display("FAIL r0_write_late got=%b want 0", write_en);
      end
   endtask

   task automatic test_set_clear();
      query_a_index = 4'd4;
      issue_en = 1; issue_index = 4'd4;
      tick();
      issue_en = 0;
      alu_valid = 1; alu_index = 4'd4; alu_data = 32'h44;
      tick();
      alu_valid = 0;
      issue_en = 1; issue_index = 4'd4;
      checks++;
      if ({write_en, write_index} !== {1'b1, 4'd4}) begin
         failures++;
         $display("FAIL sc_write got=%b/%h want 1/4", write_en, write_index);
      end
      tick();
      issue_en = 0;
      checks++;
      if (pending_a !== 1'b1) begin
         failures++;
         $display("FAIL sc_pending got=%b want 1", pending_a);
      end
   endtask

   task automatic test_reset_midflight();
      query_a_index = 4'd14; query_b_index = 4'd2; query_c_index = 4'd4;
      issue_en = 1; issue_index = 4'd2;
      alu_valid = 1; alu_index = 4'd1; alu_data = 32'hA1;
      mem_valid = 1; mem_index = 4'd2; mem_data = 32'hB2;
      tick();
      issue_en = 0;
      alu_index = 4'd14; alu_data = 32'hAE;
      mem_index = 4'd3; mem_data = 32'hB3;
      tick();
      alu_valid = 0; mem_valid = 0;
      checks++;
      if ({write_en, write_index, write, pending_b} !== {1'b1, 4'd14, 32'hAE, 1'b1}) begin
         failures++;
         $display("FAIL mid_pre got=%b/%h/%h/%b want 1/e/ae/1", write_en, write_index, write, pending_b);
      end
`ifdef WRITEBACK_BYPASS_EN
      checks++;
      if ({bypass_a, bypass_data} !== {1'b1, 32'hAE}) begin
         failures++;
         $display("FAIL mid_bypass got=%b/%h want 1/ae", bypass_a, bypass_data);
      end
`endif
      #2 rst_async_n = 1'b0;
      #1;
      checks++;
      if ({write_en, pending_a, pending_b, pending_c} !== 4'b0000) begin
         failures++;
         $display("FAIL mid_reset got=%b want 0000", {write_en, pending_a, pending_b, pending_c});
      end
      tick();
      rst_async_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (write_en !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_drain%0d got=%b want 0", i, write_en);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_contention();
      test_queue_full();
      test_r0();
      test_set_clear();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
